// File: rtl/dmem_pkg.sv
// Shared types and helpers for the multi-cycle data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    // Ceiling log2, usable in parameter expressions; clog2(1) == 0.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x DATA_W word storage: synchronous write port, asynchronous read port.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Contents are deliberately never reset so they survive a responder reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM stage; define DMEM_ZERO_WAIT_EN
// to build the zero-wait variant (no FSM, stall tied low).
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              stall,
    output logic              err
);

    localparam int IDX_W = clog2(DEPTH);
    localparam int CNT_W = clog2(LATENCY) + 1;

    // Upper address bits only select a wrap-around alias, so they are dropped.
    logic [IDX_W-1:0] index;
    logic             misaligned;
    logic             req;

    assign index      = addr[IDX_W+1:2];
    assign misaligned = (addr[1:0] != 2'b00);
    assign req        = memRead | memWrite;

`ifdef DMEM_ZERO_WAIT_EN

    logic [DATA_W-1:0] array_rdata;
    logic              unused_bits;

    assign unused_bits = ^{addr[ADDR_W-1:IDX_W+2], rst};

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (memWrite & ~misaligned),
        .waddr (index),
        .wdata (wdata),
        .raddr (index),
        .rdata (array_rdata)
    );

    assign stall       = 1'b0;
    assign rdata       = memRead ? array_rdata : '0;
    assign rdata_valid = memRead & ~memWrite;
    assign err         = req & misaligned;

`else

    state_t            state;
    op_t               op;
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  index_q;
    logic [DATA_W-1:0] wdata_q;
    logic              misaligned_q;
    logic              err_flag_q;
    logic [DATA_W-1:0] array_rdata;
    logic              access_now;
    logic              unused_bits;

    assign unused_bits = ^addr[ADDR_W-1:IDX_W+2];
    assign access_now  = (state == BUSY) && (cnt == '0);

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (access_now && (op == OP_WRITE) && !misaligned_q),
        .waddr (index_q),
        .wdata (wdata_q),
        .raddr (index_q),
        .rdata (array_rdata)
    );

    // Gating with rst keeps stall low while reset is held, even with a request up.
    always_comb begin
        stall = 1'b0;
        case (state)
            IDLE:    stall = req & rst;
            BUSY:    stall = 1'b1;
            default: stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            op           <= OP_READ;
            cnt          <= '0;
            index_q      <= '0;
            wdata_q      <= '0;
            misaligned_q <= 1'b0;
            err_flag_q   <= 1'b0;
            rdata        <= '0;
            rdata_valid  <= 1'b0;
            err          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        index_q      <= index;
                        wdata_q      <= wdata;
                        op           <= memWrite ? OP_WRITE : OP_READ;
                        misaligned_q <= misaligned;
                        err_flag_q   <= misaligned | (memRead & memWrite);
                        cnt          <= CNT_W'(LATENCY - 1);
                        state        <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        if (op == OP_READ) begin
                            rdata       <= misaligned_q ? '0 : array_rdata;
                            rdata_valid <= 1'b1;
                        end
                        err   <= err_flag_q;
                        state <= RESP;
                    end
                end
                RESP: begin
                    rdata_valid <= 1'b0;
                    err         <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder against an array-based memory model;
// honours DMEM_ZERO_WAIT_EN to exercise the zero-wait build.
module tb_dmem_responder;

    localparam int LAT   = 2;
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        memRead = 1'b0;
    logic        memWrite = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        stall;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_mem [DEPTH];
    logic [31:0] model_rdata = '0;

    always #5 clk = ~clk;

    dmem_responder #(
        .DATA_W  (32),
        .ADDR_W  (32),
        .DEPTH   (DEPTH),
        .LATENCY (LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .memRead     (memRead),
        .memWrite    (memWrite),
        .addr        (addr),
        .wdata       (wdata),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .stall       (stall),
        .err         (err)
    );

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int model_index(input logic [31:0] a);
        return int'(a >> 2) % DEPTH;
    endfunction

`ifndef DMEM_ZERO_WAIT_EN

    // One complete access: request, count stall cycles, check the response and the idle cycle after it.
    task automatic apply_stimulus(input logic rd, input logic wr, input logic [31:0] a,
                                  input logic [31:0] d, input string tag);
        int  n_stall;
        int  early;
        bit  mis;
        logic exp_err;
        logic exp_valid;

        mis       = (a % 4) != 0;
        exp_err   = mis || (rd && wr);
        exp_valid = rd && !wr;
        if (wr) begin
            if (!mis) model_mem[model_index(a)] = d;
        end else begin
            model_rdata = mis ? 32'h0 : model_mem[model_index(a)];
        end

        n_stall = 0;
        early   = 0;
        @(negedge clk);
        memRead  = rd;
        memWrite = wr;
        addr     = a;
        wdata    = d;
        #1;
        if (stall) n_stall++;
        @(posedge clk);
        #1;
        memRead  = 1'b0;
        memWrite = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!stall) break;
            n_stall++;
            if (rdata_valid || err) early++;
        end
        check_output({tag, "_stall_len"}, n_stall, LAT + 1);
        check_output({tag, "_early_strobe"}, early, 0);
        check_output({tag, "_valid"}, rdata_valid, exp_valid);
        check_output({tag, "_err"}, err, exp_err);
        check_output({tag, "_rdata"}, rdata, model_rdata);
        @(posedge clk);
        #1;
        check_output({tag, "_valid_after"}, rdata_valid, 1'b0);
        check_output({tag, "_err_after"}, err, 1'b0);
        check_output({tag, "_stall_after"}, stall, 1'b0);
    endtask

`else

    // Zero-wait: everything is visible in the same cycle; stores land at the next rising edge.
    task automatic apply_stimulus(input logic rd, input logic wr, input logic [31:0] a,
                                  input logic [31:0] d, input string tag);
        bit mis;
        mis = (a % 4) != 0;
        @(negedge clk);
        memRead  = rd;
        memWrite = wr;
        addr     = a;
        wdata    = d;
        #1;
        check_output({tag, "_stall"}, stall, 1'b0);
        check_output({tag, "_valid"}, rdata_valid, rd && !wr);
        check_output({tag, "_err"}, err, (rd || wr) && mis);
        check_output({tag, "_rdata"}, rdata, rd ? model_mem[model_index(a)] : 32'h0);
        @(posedge clk);
        if (wr && !mis) model_mem[model_index(a)] = d;
        #1;
        memRead  = 1'b0;
        memWrite = 1'b0;
    endtask

`endif

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired before end of test");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [31:0] a;
        int          sel;

`ifndef DMEM_ZERO_WAIT_EN
        // Reset held with a read request pending must keep everything quiet.
        rst     = 1'b0;
        memRead = 1'b1;
        addr    = 32'h10;
        #100;
        check_output("rst_stall", stall, 1'b0);
        check_output("rst_rdata", rdata, 32'h0);
        check_output("rst_valid", rdata_valid, 1'b0);
        check_output("rst_err", err, 1'b0);
        memRead = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_output("post_rst_stall", stall, 1'b0);
        check_output("post_rst_rdata", rdata, 32'h0);
        check_output("post_rst_valid", rdata_valid, 1'b0);
        check_output("post_rst_err", err, 1'b0);
`else
        rst = 1'b1;
        repeat (2) @(negedge clk);
`endif

        $display("[TB] filling memory");
        for (int i = 0; i < DEPTH; i++) begin
            apply_stimulus(1'b0, 1'b1, 32'(i * 4), $urandom, "fill");
        end

`ifndef DMEM_ZERO_WAIT_EN
        $display("[TB] directed accesses");
        apply_stimulus(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, "st_10");
        apply_stimulus(1'b1, 1'b0, 32'h10, 32'h0, "ld_10");
        apply_stimulus(1'b0, 1'b1, 32'h400, 32'h1234, "st_wrap");
        apply_stimulus(1'b1, 1'b0, 32'h0, 32'h0, "ld_wrap");
        apply_stimulus(1'b0, 1'b1, 32'h13, 32'hFFFFFFFF, "st_mis");
        apply_stimulus(1'b1, 1'b0, 32'h10, 32'h0, "ld_after_mis");
        apply_stimulus(1'b1, 1'b0, 32'h11, 32'h0, "ld_mis");
        apply_stimulus(1'b1, 1'b1, 32'h80, 32'hCAFEF00D, "both");

        // Reset during the last BUSY cycle must abandon the pending store.
        apply_stimulus(1'b0, 1'b1, 32'h20, 32'h77, "st_20");
        @(negedge clk);
        memWrite = 1'b1;
        addr     = 32'h20;
        wdata    = 32'h55;
        @(posedge clk);
        #1;
        memWrite = 1'b0;
        @(posedge clk);
        #1;
        check_output("abort_busy_stall", stall, 1'b1);
        rst = 1'b0;
        #1;
        check_output("abort_stall_drop", stall, 1'b0);
        check_output("abort_valid", rdata_valid, 1'b0);
        check_output("abort_rdata", rdata, 32'h0);
        model_rdata = 32'h0;
        @(negedge clk);
        rst = 1'b1;
        apply_stimulus(1'b1, 1'b0, 32'h20, 32'h0, "ld_20_after_abort");
`else
        $display("[TB] zero-wait directed accesses");
        apply_stimulus(1'b0, 1'b1, 32'h8, 32'hA5, "zw_st_8");
        apply_stimulus(1'b1, 1'b0, 32'h8, 32'h0, "zw_ld_8");
        apply_stimulus(1'b0, 1'b1, 32'h13, 32'hFFFFFFFF, "zw_st_mis");
        apply_stimulus(1'b1, 1'b0, 32'h10, 32'h0, "zw_ld_10");
`endif

        $display("[TB] random accesses");
        for (int i = 0; i < 60; i++) begin
            sel = $urandom_range(0, 2);
            a   = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            apply_stimulus(sel != 1, sel != 0, a, $urandom, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the pipelined MIPS datapath; the MEM stage issues memRead/memWrite requests into it.
- Serves word-addressed loads and stores from internal storage with a fixed, parameterised access latency.
- Drives a stall back to the pipeline while an access is in flight.
- Returns load data with a one-cycle valid strobe, replacing the zero-wait data memory for multi-cycle memory experiments.

Parameters:
- DATA_W, 32, data word width.
- ADDR_W, 32, byte address width.
- DEPTH, 256, number of words; power of two, at least 4.
- LATENCY, 2, BUSY-state cycles per access; at least 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- memRead  in  1  load request from the MEM stage.
- memWrite  in  1  store request from the MEM stage.
- addr  in  ADDR_W  byte address, equal to the ALU result.
- wdata  in  DATA_W  store data.
- rdata  out  DATA_W  load data, registered.
- rdata_valid  out  1  one-cycle strobe: rdata holds the completed load.
- stall  out  1  pipeline must hold the PC and all pipeline registers.
- err  out  1  one-cycle strobe: misaligned access was completed (and suppressed).

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, cnt=0, rdata=0, rdata_valid=0, err=0. Storage contents are not cleared. Reset during BUSY drops the pending access; a pending store never reaches storage.
- States are IDLE, BUSY and RESP.
- IDLE:
  - req = memRead | memWrite; stall = req, combinational.
  - On req, latch addr, wdata and op (write if memWrite, else read); cnt <= LATENCY-1; go to BUSY.
  - If memRead and memWrite are both high, the access is a write and err pulses in RESP.
- BUSY:
  - stall=1.
  - If cnt!=0, cnt decrements.
  - If cnt==0, at the edge perform the access (store into storage, or load into rdata) and go to RESP.
- RESP:
  - stall=0; rdata_valid=1 only if op was read; err as flagged.
  - Pipeline advances at this edge. The next state is IDLE unconditionally; request inputs are ignored in RESP.
- Stall length: a request sampled at cycle 0 keeps stall high for cycles 0..LATENCY; the response appears in cycle LATENCY+1.
- Back-to-back requests are accepted earliest in cycle LATENCY+2.
- Indexing: word index = addr[log2(DEPTH)+1:2]. Upper address bits are ignored, so out-of-range addresses wrap modulo DEPTH.
- Misalignment (addr[1:0]!=0):
  - The store is suppressed; a load returns rdata=0.
  - err=1 in RESP.
- rdata holds its value until the next completed load; rdata_valid and err are low outside RESP.

Optional Feature:
- Macro: DMEM_ZERO_WAIT_EN.
- Defined:
  - The FSM is compiled out and stall is tied to 0.
  - rdata is combinational from storage: rdata = mem[index] when memRead, else 0.
  - Stores are written on the rising edge when memWrite=1.
  - rdata_valid = memRead & ~memWrite.
  - err = memRead|memWrite AND misaligned, combinational; misaligned stores are suppressed.
  - LATENCY is ignored.
- Undefined: the FSM behaviour described above.

Decomposition:
- Package dmem_pkg holds:
  - state enum {IDLE, BUSY, RESP};
  - op enum {OP_READ, OP_WRITE};
  - function clog2 used for index width and counter width, with counter width = clog2(LATENCY)+1.
- Sub-module dmem_array: DEPTH x DATA_W storage.
  - Write port: synchronous, with we, waddr, wdata.
  - Read port: asynchronous, with raddr and rdata.
  - The responder registers rdata itself.

Test Plan:
- Reset: hold rst=0 for 100 ns with memRead=1 -> stall=0, rdata=0, rdata_valid=0, err=0. After rst=1 with no request, outputs stay the same.
- Store then load, LATENCY=2:
  - memWrite addr=0x10 wdata=0xDEADBEEF -> stall high for exactly 3 cycles, no rdata_valid.
  - Then memRead addr=0x10 -> stall high 3 cycles, then rdata=0xDEADBEEF with rdata_valid for 1 cycle.
- Wrap: store 0x1234 at addr=0x400 with DEPTH=256 -> load from addr=0x0 returns 0x1234.
- Misaligned: memWrite addr=0x13 wdata=0xFFFFFFFF -> err pulse in the RESP cycle; a later load at 0x10 still returns 0xDEADBEEF.
- Reset mid-operation: memWrite addr=0x20 wdata=0x55, rst=0 in the second BUSY cycle -> stall drops immediately; a later load at 0x20 returns the prior contents, not 0x55.
- DMEM_ZERO_WAIT_EN build:
  - store 0xA5 at 0x8 -> stall never asserts;
  - memRead at 0x8 the next cycle gives rdata=0xA5 in the same cycle with rdata_valid=1.
